intra8x8cc_loader: RTL

INTRA8X8CC_LOADER -- requirements
Module: intra8x8cc_loader

---
 rtl/intra8x8cc_pkg.sv | 32 +++
 rtl/intra8x8cc_bank_ram.sv | 40 ++++
 rtl/intra8x8cc_loader.sv | 111 +++++++++++
 3 files changed

// File: rtl/intra8x8cc_pkg.sv
// Shared constants and types for the intra8x8 chroma loader.
// Build option: define INTRA8X8CC_LOADER_DBUF_EN for two ping-pong banks;
// leave it undefined for a single bank.
package intra8x8cc_pkg;

    localparam int PIX_W          = 8;
    localparam int WORD_W         = 4 * PIX_W;
    localparam int WORDS_PER_COMP = 16;
    localparam int WORDS_PER_MB   = 2 * WORDS_PER_COMP;

`ifdef INTRA8X8CC_LOADER_DBUF_EN
    localparam int NUM_BANKS = 2;
`else
    localparam int NUM_BANKS = 1;
`endif

    localparam int RAM_DEPTH = NUM_BANKS * WORDS_PER_MB;
    localparam int RAM_AW    = $clog2(RAM_DEPTH);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bank_state_t;

    // Storage address of a word: bank bit above the {Cr/Cb, index} word
    // address. With a single bank the bank bit falls away in the cast.
    function automatic logic [RAM_AW-1:0] ram_addr(input logic bank,
                                                   input logic [4:0] word);
        return RAM_AW'({bank, word});
    endfunction

endpackage

// File: rtl/intra8x8cc_bank_ram.sv
// Chroma word storage: one synchronous write port, one registered read port.
// Only the read register is reset; the array itself keeps its contents.
module intra8x8cc_bank_ram
    import intra8x8cc_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [RAM_AW-1:0] waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [RAM_AW-1:0] raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [RAM_DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Write port: store an accepted word.
    // NOTE: the array has no reset so it maps onto block RAM; clearing it
    // would turn it into a flop bank and reset cannot touch it anyway.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port: registered data, cleared by reset.
    // NOTE: sequential state uses <= so every register samples the values
    // from before the edge, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/intra8x8cc_loader.sv
// Intra8x8 chroma loader: collects 32 words (16 Cb then 16 Cr) per
// macroblock into a bank and hands complete banks to the consumer.
// Build option: INTRA8X8CC_LOADER_DBUF_EN selects ping-pong double buffering
// (load next macroblock while the current one is read); undefined gives one
// bank that blocks loading until the consumer releases it.
module intra8x8cc_loader
    import intra8x8cc_pkg::*;
(
    input  logic              CLK2,
    input  logic              NEWLINE,
    input  logic              STROBEI,
    input  logic [WORD_W-1:0] DATAI,
    output logic              READYI,
    output logic [4:0]        istate,
    output logic              bank_valid,
    input  logic              rd_crcb,
    input  logic [3:0]        rd_addr,
    output logic [WORD_W-1:0] rd_data,
    input  logic              rd_release,
    output logic              ovf
);

    logic [4:0]  istate_q, istate_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        ovf_q, ovf_d;
    bank_state_t bank_q [2];
    bank_state_t bank_d [2];

    logic accept;
    logic release_ok;
    logic last_word;

    assign READYI     = (bank_q[wr_ptr_q] == EMPTY);
    assign bank_valid = (bank_q[rd_ptr_q] == FULL);
    assign accept     = STROBEI && READYI;
    assign release_ok = rd_release && bank_valid;
    assign last_word  = (istate_q == 5'd31);

    // Next-state: word counter, bank handshake, pointers and overflow flag.
    // NOTE: every variable gets its default first so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        istate_d = istate_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        bank_d   = bank_q;

        if (accept) begin
            istate_d = istate_q + 5'd1;
            if (last_word) begin
                bank_d[wr_ptr_q] = FULL;
`ifdef INTRA8X8CC_LOADER_DBUF_EN
                wr_ptr_d = ~wr_ptr_q;
`else
                wr_ptr_d = 1'b0;
`endif
            end
        end

        // A strobe that finds no free bank is lost; remember it.
        if (STROBEI && !READYI) begin
            ovf_d = 1'b1;
        end

        // The write bank is EMPTY and the read bank FULL whenever both of
        // these fire, so they never target the same bank.
        if (release_ok) begin
            bank_d[rd_ptr_q] = EMPTY;
`ifdef INTRA8X8CC_LOADER_DBUF_EN
            rd_ptr_d = ~rd_ptr_q;
`else
            rd_ptr_d = 1'b0;
`endif
        end
    end

    // State registers; reset discards any partial bank but not its data.
    always_ff @(posedge CLK2) begin
        if (NEWLINE) begin
            istate_q  <= 5'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            ovf_q     <= 1'b0;
            bank_q[0] <= EMPTY;
            bank_q[1] <= EMPTY;
        end else begin
            istate_q  <= istate_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovf_q     <= ovf_d;
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
        end
    end

    assign istate = istate_q;
    assign ovf    = ovf_q;

    intra8x8cc_bank_ram u_ram (
        .clk_i   (CLK2),
        .rst_i   (NEWLINE),
        .we_i    (accept),
        .waddr_i (ram_addr(wr_ptr_q, istate_q)),
        .wdata_i (DATAI),
        .raddr_i (ram_addr(rd_ptr_q, {rd_crcb, rd_addr})),
        .rdata_o (rd_data)
    );

endmodule
